pin_debounce: RTL and testbench

Input conditioner for the board header pins (J1 bus) that sits directly upstream of the combinational logic stages (e.g. the 4-input NAND array) in the ice40 top level. Each bit passes through a multi-flop synchronizer and a per-bit stability counter. The block presents a clean, glitch-free registered bus plus per-bit edge strobes and a bus-level change strobe. Downstream logic consumes O in place of raw pins.

---
 rtl/pin_debounce.sv | 139 +++++++++++++
 tb/tb_pin_debounce.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pin_debounce.sv
// -----------------------------------------------------------------------------
// pin_debounce
//
// Input conditioner for the J1 header pins. Every bit of the raw pin bus is
// brought into the CLK domain through a SYNC_STAGES-deep flop chain and then
// filtered by its own stability counter. O only changes after the synchronized
// level has disagreed with it for DEBOUNCE_CYCLES consecutive counted edges.
// Any return to the current O value clears the partial count. The per-bit
// RISE/FALL strobes and the bus-level CHANGED strobe are registered, so they
// line up with the cycle in which O shows its new value.
//
// Ports:
//   CLK      in   1      single clock; all state updates on its rising edge
//   RESETN   in   1      asynchronous active-low reset (release synchronous)
//   CE       in   1      count enable; low holds counters and O, and blanks
//                        the strobes, while the synchronizer keeps shifting
//   I        in   WIDTH  raw asynchronous pin inputs
//   O        out  WIDTH  debounced stable value
//   RISE     out  WIDTH  one-cycle pulse per bit when O[n] goes 0->1
//   FALL     out  WIDTH  one-cycle pulse per bit when O[n] goes 1->0
//   CHANGED  out  1      one-cycle pulse when any bit of O flips
// -----------------------------------------------------------------------------
module pin_debounce #(
  parameter int              WIDTH           = 8,
  parameter int              SYNC_STAGES     = 2,
  parameter int              DEBOUNCE_CYCLES = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE    = '0
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             CE,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] O,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL,
  output logic             CHANGED
);

  // Counter width is max(1, clog2(DEBOUNCE_CYCLES)); terminal count is
  // DEBOUNCE_CYCLES-1, so the counter never needs to represent D itself.
  localparam int              CNT_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Elaboration-time guards on the legal parameter ranges.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("pin_debounce: SYNC_STAGES must be in 2..4");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("pin_debounce: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;

  logic [WIDTH-1:0] o_q, o_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             changed_q, changed_d;

  // ---------------------------------------------------------------------------
  // Synchronizer: plain shift chain, nothing between stages so every stage
  // gets a full cycle to resolve metastability.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= RESET_VALUE;
      end
    end else begin
      sync_q[0] <= I;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Per-bit stability counters. Each bit is fully independent.
  // ---------------------------------------------------------------------------
  for (genvar n = 0; n < WIDTH; n++) begin : g_bit
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d     = cnt_q;
      o_d[n]    = o_q[n];
      rise_d[n] = 1'b0;
      fall_d[n] = 1'b0;
      if (CE) begin
        if (s[n] == o_q[n]) begin
          // Level agrees with O: any partial count is a glitch, drop it.
          cnt_d = '0;
        end else if (cnt_q == CNT_TC) begin
          o_d[n]    = s[n];
          cnt_d     = '0;
          rise_d[n] = s[n];
          fall_d[n] = ~s[n];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  assign changed_d = |(rise_d | fall_d);

  // ---------------------------------------------------------------------------
  // Output registers: O and the strobes update on the same edge, so a strobe
  // is visible exactly in the first cycle that O carries its new value.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      o_q       <= RESET_VALUE;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      o_q       <= o_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end

  assign O       = o_q;
  assign RISE    = rise_q;
  assign FALL    = fall_q;
  assign CHANGED = changed_q;

endmodule

// File: tb/tb_pin_debounce.sv
// -----------------------------------------------------------------------------
// tb_pin_debounce
//
// Three pin_debounce instances with different parameter sets share one set of
// stimulus. A behavioural model decides each flip from the rule "the last
// DEBOUNCE_CYCLES counted samples since the previous flip all disagreed with
// O", reading the synchronized level straight out of an input history array.
// -----------------------------------------------------------------------------
module tb_pin_debounce;

  localparam int NI   = 3;
  localparam int HMAX = 8192;
  localparam int             DV [NI] = '{4, 16, 1};
  localparam int             SV [NI] = '{2, 2, 3};
  localparam logic [7:0]     RV [NI] = '{8'h00, 8'h00, 8'h3C};

  logic       CLK = 1'b0;
  logic       RESETN = 1'b0;
  logic       CE = 1'b1;
  logic [7:0] I = 8'hFF;

  logic [7:0] o_w    [NI];
  logic [7:0] rise_w [NI];
  logic [7:0] fall_w [NI];
  logic       chg_w  [NI];

  always #5 CLK = ~CLK;

  pin_debounce #(.WIDTH(8), .SYNC_STAGES(SV[0]), .DEBOUNCE_CYCLES(DV[0]), .RESET_VALUE(RV[0]))
    u_dut0 (.CLK(CLK), .RESETN(RESETN), .CE(CE), .I(I),
            .O(o_w[0]), .RISE(rise_w[0]), .FALL(fall_w[0]), .CHANGED(chg_w[0]));
  pin_debounce #(.WIDTH(8), .SYNC_STAGES(SV[1]), .DEBOUNCE_CYCLES(DV[1]), .RESET_VALUE(RV[1]))
    u_dut1 (.CLK(CLK), .RESETN(RESETN), .CE(CE), .I(I),
            .O(o_w[1]), .RISE(rise_w[1]), .FALL(fall_w[1]), .CHANGED(chg_w[1]));
  pin_debounce #(.WIDTH(8), .SYNC_STAGES(SV[2]), .DEBOUNCE_CYCLES(DV[2]), .RESET_VALUE(RV[2]))
    u_dut2 (.CLK(CLK), .RESETN(RESETN), .CE(CE), .I(I),
            .O(o_w[2]), .RISE(rise_w[2]), .FALL(fall_w[2]), .CHANGED(chg_w[2]));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [7:0] ih  [HMAX];   // I value seen at each edge since reset release
  bit         ceh [HMAX];   // CE value seen at each edge
  int         t;            // edges since reset release
  logic [7:0] mo [NI];
  logic [7:0] er [NI];
  logic [7:0] ef [NI];
  int         lastflip [NI][8];

  // Synchronized level the filter of instance k looks at on edge j.
  function automatic logic sseen(int k, int j, int n);
    logic [7:0] v;
    if (j - SV[k] >= 0) v = ih[j - SV[k]];
    else                v = RV[k];
    return v[n];
  endfunction

  task automatic model_reset();
    t = 0;
    for (int k = 0; k < NI; k++) begin
      mo[k] = RV[k];
      er[k] = '0;
      ef[k] = '0;
      for (int n = 0; n < 8; n++) lastflip[k][n] = -1;
    end
  endtask

  task automatic model_step();
    ih[t]  = I;
    ceh[t] = CE;
    for (int k = 0; k < NI; k++) begin
      er[k] = '0;
      ef[k] = '0;
      if (CE) begin
        for (int n = 0; n < 8; n++) begin
          int run = 0;
          int j   = t;
          bit ok  = 1'b1;
          while (j > lastflip[k][n] && run < DV[k] && ok) begin
            if (ceh[j]) begin
              if (sseen(k, j, n) != mo[k][n]) run++;
              else ok = 1'b0;
            end
            j--;
          end
          if (run == DV[k]) begin
            if (mo[k][n] == 1'b0) er[k][n] = 1'b1;
            else                  ef[k][n] = 1'b1;
            mo[k][n]       = ~mo[k][n];
            lastflip[k][n] = t;
          end
        end
      end
    end
    if (t < HMAX - 1) t++;
  endtask

  // Every cycle: advance the model on the edge, compare just after it.
  always @(posedge CLK) begin
    if (RESETN) model_step();
    #1;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("O[%0d]", k),       o_w[k],    mo[k]);
      check($sformatf("RISE[%0d]", k),    rise_w[k], er[k]);
      check($sformatf("FALL[%0d]", k),    fall_w[k], ef[k]);
      check($sformatf("CHANGED[%0d]", k), chg_w[k],  |(er[k] | ef[k]));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic nx(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic check_reset_state(input string tag);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("%s_O[%0d]", tag, k),    o_w[k], RV[k]);
      check($sformatf("%s_STB[%0d]", tag, k),  {rise_w[k] | fall_w[k]}, 8'h00);
      check($sformatf("%s_CHG[%0d]", tag, k),  chg_w[k], 1'b0);
    end
  endtask

  task automatic rst_seq(input logic [7:0] iv, input int settle);
    RESETN = 1'b0;
    model_reset();
    I  = iv;
    CE = 1'b1;
    nx(2);
    RESETN = 1'b1;
    nx(settle);
  endtask

  initial begin
    model_reset();

    // Reset with all pins high, then release.
    nx(3);
    check_reset_state("rst_hold");
    RESETN = 1'b1;
    nx(5);
    check("rst_rel_e5_O0", o_w[0], 8'h00);
    nx(1);
    check("rst_rel_e6_O0",    o_w[0],    8'hFF);
    check("rst_rel_e6_RISE0", rise_w[0], 8'hFF);
    check("rst_rel_e6_CHG0",  chg_w[0],  1'b1);
    nx(1);
    check("rst_rel_e7_RISE0", rise_w[0], 8'h00);
    check("rst_rel_e7_CHG0",  chg_w[0],  1'b0);

    // Latency on the D=16 instance.
    rst_seq(8'h00, 25);
    I = 8'h01;
    nx(17);
    check("lat_e17_O1", o_w[1], 8'h00);
    nx(1);
    check("lat_e18_O1",    o_w[1],    8'h01);
    check("lat_e18_RISE1", rise_w[1], 8'h01);
    nx(1);
    check("lat_e19_RISE1", rise_w[1], 8'h00);

    // Glitch rejection on the D=4 instance.
    rst_seq(8'h00, 25);
    I = 8'h08;
    nx(3);
    I = 8'h00;
    nx(8);
    check("glitch3_O0", o_w[0], 8'h00);
    I = 8'h08;
    nx(5);
    I = 8'h00;
    nx(1);
    check("glitch5_O0", o_w[0], 8'h08);
    nx(5);
    check("glitch5_FALL0", fall_w[0], 8'h08);
    check("glitch5_Oback", o_w[0],    8'h00);

    // CE hold preserves the partial count.
    rst_seq(8'h00, 25);
    I = 8'h02;
    nx(4);
    CE = 1'b0;
    nx(10);
    check("ce_hold_O0", o_w[0], 8'h00);
    CE = 1'b1;
    nx(1);
    check("ce_c3_O0", o_w[0], 8'h00);
    nx(1);
    check("ce_c4_O0",    o_w[0],    8'h02);
    check("ce_c4_RISE0", rise_w[0], 8'h02);

    // Simultaneous multi-bit changes.
    rst_seq(8'h00, 25);
    I = 8'hA5;
    nx(5);
    check("sim_e5_O0", o_w[0], 8'h00);
    nx(1);
    check("sim_e6_O0",    o_w[0],    8'hA5);
    check("sim_e6_RISE0", rise_w[0], 8'hA5);
    check("sim_e6_FALL0", fall_w[0], 8'h00);
    check("sim_e6_CHG0",  chg_w[0],  1'b1);
    nx(1);
    check("sim_e7_CHG0", chg_w[0], 1'b0);
    nx(10);
    I = 8'h5A;
    nx(6);
    check("sim2_RISE0", rise_w[0], 8'h5A);
    check("sim2_FALL0", fall_w[0], 8'hA5);
    check("sim2_O0",    o_w[0],    8'h5A);

    // Asynchronous reset in the middle of a count.
    rst_seq(8'h00, 25);
    I = 8'h01;
    nx(6);
    @(posedge CLK);
    #3;
    RESETN = 1'b0;
    model_reset();
    I = 8'h00;
    #1;
    check_reset_state("async_mid");
    nx(2);
    RESETN = 1'b1;
    nx(25);
    check("async_after_O1", o_w[1], 8'h00);

    // Randomised phase: bits toggle with random dwell, CE mostly high,
    // occasional asynchronous resets at an off-edge time.
    rst_seq(8'($urandom), 5);
    for (int c = 0; c < 3000; c++) begin
      logic [7:0] tog;
      tog = '0;
      for (int n = 0; n < 8; n++) begin
        if ($urandom_range(0, 5) == 0) tog[n] = 1'b1;
      end
      I  = I ^ tog;
      CE = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 399) == 0) begin
        #2;
        RESETN = 1'b0;
        model_reset();
        #1;
        check_reset_state("rand_rst");
        nx(2);
        RESETN = 1'b1;
      end
      nx(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
